// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared sizes and loader constants for the byte-stream program loader.
//   - SIZE_DATA / SIZE_ADDR : default instruction word and imem address widths
//   - SYNC_BYTE_DEFAULT     : default frame start marker
//   - state_t               : loader FSM state encoding
//   - bytes_per_word()      : bytes needed to carry one instruction word
package imem_loader_pkg;

    localparam int SIZE_DATA = 32;
    localparam int SIZE_ADDR = 10;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5
    } state_t;

    function automatic int bytes_per_word(input int data_w);
        return (data_w + 7) / 8;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream handshake plus imem write port used by the loader.
//   - iw_valid / iw_byte / or_ready : byte source handshake
//   - or_mem_we / or_mem_addr / or_mem_wdata : imem port 1 write
//   master : byte source / imem side
//   slave  : the loader
interface imem_loader_if #(
    parameter int DATA_W = imem_loader_pkg::SIZE_DATA,
    parameter int ADDR_W = imem_loader_pkg::SIZE_ADDR
) ();

    logic              iw_valid;
    logic [7:0]        iw_byte;
    logic              or_ready;
    logic              or_mem_we;
    logic [ADDR_W-1:0] or_mem_addr;
    logic [DATA_W-1:0] or_mem_wdata;

    modport master (
        output iw_valid, iw_byte,
        input  or_ready, or_mem_we, or_mem_addr, or_mem_wdata
    );

    modport slave (
        input  iw_valid, iw_byte,
        output or_ready, or_mem_we, or_mem_addr, or_mem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Framed byte-stream program loader. Frame: SYNC, LEN_HI, LEN_LO, N words
//   of payload (MSB-first), CSUM = XOR of length and payload bytes. Each
//   assembled word is written to imem for one cycle. The core is held in
//   reset until a frame arrives with a correct checksum.
//   Ports:
//   - iw_clk, iw_rst : clock, asynchronous active-high reset
//   - bus            : byte handshake and imem write port (slave side)
//   - or_cpu_rst     : core reset request, active-high
//   - or_busy        : frame in progress
//   - or_done        : sticky, last frame loaded with good checksum
//   - or_err         : sticky, last frame had a checksum mismatch
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int               DATA_W    = SIZE_DATA,
    parameter int               ADDR_W    = SIZE_ADDR,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]       SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic         iw_clk,
    input  logic         iw_rst,
    imem_loader_if.slave bus,
    output logic         or_cpu_rst,
    output logic         or_busy,
    output logic         or_done,
    output logic         or_err
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int SH_W  = BPW * 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    state_t             state, state_nx;
    logic [15:0]        len_q;
    logic [7:0]         csum_q;
    logic [CNT_W-1:0]   bcnt_q;
    logic [SH_W-1:0]    sh_q;
    logic [SH_W+7:0]    sh_ext;
    logic [SH_W-1:0]    sh_nx;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic               accept;
    logic               last_byte;

    // Ready depends on state only; it is forced low while reset is held so
    // the source never sees a transfer window during reset.
    assign bus.or_ready     = (state != ST_WRITE) && !iw_rst;
    assign bus.or_mem_we    = (state == ST_WRITE);
    assign bus.or_mem_addr  = mem_addr_q;
    assign bus.or_mem_wdata = mem_wdata_q;

    assign accept    = bus.iw_valid && bus.or_ready;
    assign last_byte = (bcnt_q == CNT_W'(BPW - 1));

    // Going through a wider vector keeps the shift legal when BPW == 1.
    assign sh_ext = {sh_q, bus.iw_byte};
    assign sh_nx  = sh_ext[SH_W-1:0];

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx; otherwise a latch is inferred.
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (accept && bus.iw_byte == SYNC_BYTE) state_nx = ST_LEN_HI;
            ST_LEN_HI: if (accept) state_nx = ST_LEN_LO;
            ST_LEN_LO: if (accept)
                           state_nx = ({len_q[15:8], bus.iw_byte} == 16'd0) ? ST_CSUM : ST_DATA;
            ST_DATA:   if (accept && last_byte) state_nx = ST_WRITE;
            ST_WRITE:  state_nx = (len_q == 16'd1) ? ST_CSUM : ST_DATA;
            ST_CSUM:   if (accept) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            // NOTE: non-blocking everywhere in clocked logic so every register sees pre-edge values.
            len_q       <= '0;
            csum_q      <= '0;
            bcnt_q      <= '0;
            sh_q        <= '0;
            addr_q      <= BASE_ADDR;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            or_cpu_rst  <= 1'b1;
            or_busy     <= 1'b0;
            or_done     <= 1'b0;
            or_err      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (accept && bus.iw_byte == SYNC_BYTE) begin
                    or_done    <= 1'b0;
                    or_err     <= 1'b0;
                    or_busy    <= 1'b1;
                    or_cpu_rst <= 1'b1;
                    addr_q     <= BASE_ADDR;
                    csum_q     <= '0;
                    bcnt_q     <= '0;
                end
                ST_LEN_HI: if (accept) begin
                    len_q[15:8] <= bus.iw_byte;
                    csum_q      <= csum_q ^ bus.iw_byte;
                end
                ST_LEN_LO: if (accept) begin
                    len_q[7:0] <= bus.iw_byte;
                    csum_q     <= csum_q ^ bus.iw_byte;
                    bcnt_q     <= '0;
                end
                ST_DATA: if (accept) begin
                    sh_q   <= sh_nx;
                    csum_q <= csum_q ^ bus.iw_byte;
                    if (last_byte) begin
                        // Capture the write beat here so it is registered during WRITE
                        // and holds afterwards.
                        bcnt_q      <= '0;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= sh_nx[DATA_W-1:0];
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end
                ST_WRITE: begin
                    addr_q <= addr_q + 1'b1;
                    len_q  <= len_q - 16'd1;
                end
                ST_CSUM: if (accept) begin
                    or_busy <= 1'b0;
                    if (bus.iw_byte == csum_q) begin
                        or_done    <= 1'b1;
                        or_cpu_rst <= 1'b0;
                    end else begin
                        or_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader. It is the writer on the instruction-memory port that the core's fetch stage only reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles bytes into instruction words.
- Writes each word into imem through the imem write port (port 1).
- Holds the core in reset from power-up until a frame loads with a correct checksum.
- Sits beside the core in the top level, between an external byte source (host link / testbench) and u_imem port 1.

Parameters:
- DATA_W, `SIZE_DATA, instruction word width in bits.
- ADDR_W, `SIZE_ADDR, imem address width in bits.
- BASE_ADDR, 0, imem address of the first loaded word.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_valid  in  1  byte source has a byte.
- iw_byte  in  8  byte data.
- or_ready  out  1  loader accepts the byte this cycle.
- or_mem_we  out  1  imem write enable.
- or_mem_addr  out  ADDR_W  imem write address.
- or_mem_wdata  out  DATA_W  imem write data.
- or_cpu_rst  out  1  core reset request, active-high.
- or_busy  out  1  frame in progress.
- or_done  out  1  sticky: last frame loaded with good checksum.
- or_err  out  1  sticky: last frame had a checksum mismatch.

Behaviour:
- Constants: BPW = (DATA_W+7)/8 bytes per word.
- Handshake: a byte transfers on a rising edge with iw_valid && or_ready. or_ready is combinational from state only, never from iw_valid.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO (word count N, 16 bits), N*BPW payload bytes MSB-first, CSUM.
  - CSUM is the XOR of LEN_HI, LEN_LO and all payload bytes.
- Reset values: or_ready=0, or_mem_we=0, or_mem_addr=BASE_ADDR, or_mem_wdata=0, or_cpu_rst=1, or_busy=0, or_done=0, or_err=0. FSM resets to IDLE.
- FSM states:
  - IDLE: ready=1. Non-SYNC bytes are accepted and discarded. On SYNC: clear done/err, set busy, set cpu_rst=1, addr=BASE_ADDR, xor=0 → LEN_HI.
  - LEN_HI: ready=1. Accepted byte goes to len[15:8] and is XORed into xor → LEN_LO.
  - LEN_LO: ready=1. Accepted byte goes to len[7:0] and is XORed into xor. Next state is DATA, or CSUM if the resulting len==0.
  - DATA: ready=1. Shift register sh = {sh, byte}; xor ^= byte; byte counter counts 0..BPW-1. On byte BPW-1 → WRITE.
  - WRITE: ready=0, exactly one cycle.
    - or_mem_we=1, or_mem_wdata=sh[DATA_W-1:0] (upper pad bits dropped), or_mem_addr=current addr.
    - Then addr+1 (wraps mod 2^ADDR_W) and len-1.
    - Next state is DATA if len-1 != 0, else CSUM.
  - CSUM: ready=1. On accept, compare the byte with xor.
    - Equal: done=1, cpu_rst=0.
    - Not equal: err=1, cpu_rst stays 1.
    - In both cases busy=0 → IDLE.
- Latency: the imem write occurs the cycle after the last byte of a word is accepted. Peak throughput is BPW bytes per BPW+1 cycles.
- or_mem_addr/or_mem_wdata are registered and hold their value outside WRITE. or_mem_we is high only in WRITE.
- A SYNC_BYTE value inside LEN/DATA/CSUM is ordinary data; there is no resync mid-frame.
- A new SYNC after DONE re-asserts or_cpu_rst on the accept edge (reload semantics).
- Words written before a bad CSUM remain in imem. The error is flagged only; or_cpu_rst stays 1.
- iw_rst mid-frame: immediate return to reset values. The partial frame is abandoned and no further writes occur.
- len counter is 16 bits. N > 2^ADDR_W wraps addresses and overwrites earlier words; this is legal and not flagged.

Decomposition:
- Shared sizes header holds DATA_W/ADDR_W defaults (existing `SIZE_DATA, `SIZE_ADDR).
- New loader header holds the SYNC_BYTE default and the state encodings (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM).
- Single module; no sub-module is warranted.
- Top level ties port 1 of the imem port arrays to this block and ORs or_cpu_rst into the core's iw_rst.

Test Plan:
- Reset, then idle stream 00,FF → or_ready=1, no writes, or_cpu_rst=1, done=0, err=0.
- DATA_W=24: frame A5,00,02,11,22,33,44,55,66,CSUM=00^02^11^22^33^44^55^66 → we pulses at imem[0]=112233 and imem[1]=445566. done=1, cpu_rst falls after the CSUM accept.
- Same frame with CSUM^01 → both words written, err=1, done=0, cpu_rst=1.
- Zero-length frame A5,00,00,00 → no we pulses, done=1, cpu_rst=0.
- Byte source with random iw_valid gaps, plus a check that WRITE holds or_ready=0 for one cycle → identical imem contents and no lost or duplicated bytes.
- iw_rst asserted after 4 payload bytes, then a full valid frame → no write from the aborted frame after reset; second frame loads correctly. Also: reload after DONE re-asserts cpu_rst on the SYNC edge.
